// File: rtl/adder_pkg.sv
// Shared definitions for the serial arithmetic blocks: state encoding and counter sizing.
package adder_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_RUN  = RUN,
    ST_DONE = DONE
  } state_e;

  // Bit-counter width for a WIDTH-step operation; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_adder_fsm_if.sv
// Request/result bundle of the bit-serial adder.
interface serial_adder_fsm_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout, ovf
  );

endinterface

// File: rtl/fa_cell.sv
// Combinational single-bit full adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_fsm.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop, LSB first,
// WIDTH RUN cycles per operation, result published only at completion.
module serial_adder_fsm
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_adder_fsm_if.slave bus
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  logic [WIDTH-2:0] sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] sum_next;

  fa_cell u_fa (
    .a   (sh_a_q[0]),
    .b   (sh_b_q[0]),
    .cin (carry_q),
    .s   (fa_s),
    .cout(fa_co)
  );

  // New sum bit enters at the MSB; the full word is complete on the last step.
  assign sum_next = {fa_s, sum_sh_q};

  always_comb begin
    state_d  = state_q;
    sh_a_d   = sh_a_q;
    sh_b_d   = sh_b_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          sh_a_d  = bus.a;
          sh_b_d  = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1 : bus.cin;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        sh_a_d   = {1'b0, sh_a_q[WIDTH-1:1]};
        sh_b_d   = {1'b0, sh_b_q[WIDTH-1:1]};
        sum_sh_d = sum_next[WIDTH-1:1];
        carry_d  = fa_co;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // carry_q here is the carry into the MSB
          state_d = ST_DONE;
          sum_d   = sum_next;
          cout_d  = fa_co;
          ovf_d   = carry_q ^ fa_co;
          cnt_d   = '0;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sh_a_q   <= '0;
      sh_b_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_a_q   <= sh_a_d;
      sh_b_q   <= sh_b_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_fsm.sv
// Scoreboarded bench for serial_adder_fsm (WIDTH=8): directed vectors plus model-checked sweeps.
module tb_serial_adder_fsm;

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  serial_adder_fsm_if #(.WIDTH(8)) bus ();

  serial_adder_fsm #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int tests    = 0;
  int fails    = 0;
  int done_cnt = 0;
  int issued   = 0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                 input logic cin, input logic sub);
    logic [7:0] bb;
    logic       c;
    logic [8:0] t;
    exp_t       e;
    bb = sub ? ~b : b;
    c  = sub ? 1'b1 : cin;
    t  = {1'b0, a} + {1'b0, bb} + 9'(c);
    e.sum  = t[7:0];
    e.cout = t[8];
    e.ovf  = (a[7] == bb[7]) && (t[7] != a[7]);
    return e;
  endfunction

  // Monitor: every done pulse consumes one expectation.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      done_cnt++;
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 expected no pulse at %0t", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("sum", 64'(bus.sum), 64'(e.sum));
        check("cout", 64'(bus.cout), 64'(e.cout));
        check("ovf", 64'(bus.ovf), 64'(e.ovf));
      end
    end
  end

  task automatic wait_done(input string nm);
    bit seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got no done expected done within 20 cycles", nm);
    end
  endtask

  task automatic run_op(input logic [7:0] a_i, input logic [7:0] b_i, input logic cin_i,
                        input logic sub_i, input exp_t e);
    @(negedge clk);
    bus.a = a_i; bus.b = b_i; bus.cin = cin_i; bus.sub = sub_i; bus.start = 1'b1;
    q.push_back(e);
    issued++;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = 8'($urandom); bus.b = 8'($urandom);
    bus.cin = 1'($urandom); bus.sub = 1'($urandom);
    wait_done("op");
    @(negedge clk);
  endtask

  initial begin
    int bsy;
    int dc0;
    logic [7:0] corner [4];
    logic [7:0] ra, rb;
    logic rc, rs;

    bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_sum", 64'(bus.sum), 64'd0);
    check("rst_cout", 64'(bus.cout), 64'd0);
    check("rst_ovf", 64'(bus.ovf), 64'd0);
    rst_n = 1'b1;

    run_op(8'h0F, 8'h01, 1'b0, 1'b0, '{sum: 8'h10, cout: 1'b0, ovf: 1'b0});
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, '{sum: 8'h00, cout: 1'b1, ovf: 1'b0});
    run_op(8'h7F, 8'h00, 1'b1, 1'b0, '{sum: 8'h80, cout: 1'b0, ovf: 1'b1});
    run_op(8'h05, 8'h07, 1'b1, 1'b1, '{sum: 8'hFE, cout: 1'b0, ovf: 1'b0});
    run_op(8'h80, 8'h01, 1'b0, 1'b1, '{sum: 8'h7F, cout: 1'b1, ovf: 1'b1});

    // Second start while busy must be dropped
    dc0 = done_cnt;
    bsy = 0;
    @(negedge clk);
    bus.a = 8'h33; bus.b = 8'h44; bus.cin = 1'b0; bus.sub = 1'b0; bus.start = 1'b1;
    q.push_back('{sum: 8'h77, cout: 1'b0, ovf: 1'b0});
    issued++;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 3) begin
        bus.a = 8'hF0; bus.b = 8'hF0; bus.sub = 1'b1; bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.busy) bsy++;
      if (bus.done) break;
    end
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    check("busy_cycles", 64'(bsy), 64'd8);
    check("single_done", 64'(done_cnt - dc0), 64'd1);

    // Reset mid-operation aborts without a done pulse
    @(negedge clk);
    bus.a = 8'hAB; bus.b = 8'hCD; bus.sub = 1'b0; bus.cin = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_sum", 64'(bus.sum), 64'd0);
    check("abort_cout", 64'(bus.cout), 64'd0);
    check("abort_ovf", 64'(bus.ovf), 64'd0);
    rst_n = 1'b1;
    repeat (14) @(negedge clk);
    run_op(8'h12, 8'h34, 1'b0, 1'b1, '{sum: 8'hDE, cout: 1'b0, ovf: 1'b0});

    // Corner operands in both modes
    corner[0] = 8'h00; corner[1] = 8'hFF; corner[2] = 8'h80; corner[3] = 8'h7F;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        for (int s = 0; s < 2; s++)
          run_op(corner[i], corner[j], 1'(j), 1'(s),
                 model(corner[i], corner[j], 1'(j), 1'(s)));

    for (int n = 0; n < 250; n++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      rc = 1'($urandom); rs = 1'($urandom);
      run_op(ra, rb, rc, rs, model(ra, rb, rc, rs));
    end

    repeat (5) @(negedge clk);
    check("queue_drained", 64'(q.size()), 64'd0);
    check("done_total", 64'(done_cnt), 64'(issued));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
